// File: rtl/cpu_control_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_mc_if
// Description : Signal bundle between the multi-cycle control unit and the
//               accumulator datapath / memories.
//               master modport = control unit side, slave = datapath side.
//   Datapath -> control : opcode[OPCODE_W], is_zero, is_neg, mem_ready, resume
//   Control -> datapath : pc_load, pc_en, halt, jmp, ir_load,
//                         accumulator_load, alu_op[3], memIns_en, memDa_en,
//                         memDa_we, state[4], err_illegal, err_timeout,
//                         instr_count[CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_control_mc_if #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                is_zero;
    logic                is_neg;
    logic                mem_ready;
    logic                resume;

    logic                pc_load;
    logic                pc_en;
    logic                halt;
    logic                jmp;
    logic                ir_load;
    logic                accumulator_load;
    logic [2:0]          alu_op;
    logic                memIns_en;
    logic                memDa_en;
    logic                memDa_we;
    logic [3:0]          state;
    logic                err_illegal;
    logic                err_timeout;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, is_zero, is_neg, mem_ready, resume,
        output pc_load, pc_en, halt, jmp, ir_load, accumulator_load, alu_op,
               memIns_en, memDa_en, memDa_we, state, err_illegal, err_timeout,
               instr_count
    );

    modport slave (
        output opcode, is_zero, is_neg, mem_ready, resume,
        input  pc_load, pc_en, halt, jmp, ir_load, accumulator_load, alu_op,
               memIns_en, memDa_en, memDa_we, state, err_illegal, err_timeout,
               instr_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_mc.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_mc
// Description : Multi-cycle control unit for the accumulator CPU.
//               FETCH -> DECODE -> (OP_FETCH) -> EXEC | STORE -> FETCH,
//               with a resumable HALT, sticky error flags, a data-memory
//               wait/timeout counter and a saturating retired-instr counter.
//   clk : system clock (rising edge)
//   rst : asynchronous, active-low reset
//   bus : cpu_control_mc_if master modport (all decode inputs / controls)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_mc #(
    parameter int OPCODE_W     = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cpu_control_mc_if.master  bus
);
    // One spare bit so the counter can hold MEM_WAIT_MAX for any value >= 0.
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 2);

    localparam logic [3:0] C_OP_HLT = 4'd0,  C_OP_SKZ = 4'd1,  C_OP_ADD = 4'd2;
    localparam logic [3:0] C_OP_AND = 4'd3,  C_OP_XOR = 4'd4,  C_OP_LDA = 4'd5;
    localparam logic [3:0] C_OP_STO = 4'd6,  C_OP_JMP = 4'd7,  C_OP_SKN = 4'd8;
    localparam logic [3:0] C_OP_SUB = 4'd9,  C_OP_OR  = 4'd10, C_OP_JZ  = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_OP_FETCH = 4'd2,
        S_EXEC     = 4'd3,
        S_STORE    = 4'd4,
        S_HALT     = 4'd8
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_err_illegal;
    logic               r_err_timeout;
    logic [CNT_W-1:0]   r_instr_count;

    state_t             w_next;
    logic [3:0]         w_op;
    logic [2:0]         w_alu_sel;
    logic               w_is_alu, w_illegal, w_at_limit;
    logic               w_set_ill, w_set_to, w_retire, w_wait_inc;
    logic               w_pc_load, w_pc_en, w_halt, w_jmp, w_ir_load, w_acc_load;
    logic [2:0]         w_alu_op;
    logic               w_memIns_en, w_memDa_en, w_memDa_we;

    // With a 3-bit opcode the upper half of the map (extended and illegal
    // opcodes) simply cannot be decoded.
    generate
        if (OPCODE_W == 3) begin : g_op3
            assign w_op = {1'b0, bus.opcode};
        end else begin : g_op4
            assign w_op = bus.opcode;
        end
    endgenerate

    assign w_illegal  = (w_op >= 4'd12);
    assign w_is_alu   = (w_op == C_OP_ADD) || (w_op == C_OP_AND) || (w_op == C_OP_XOR) ||
                        (w_op == C_OP_LDA) || (w_op == C_OP_SUB) || (w_op == C_OP_OR);
    assign w_at_limit = (r_wait_cnt == WAIT_W'(MEM_WAIT_MAX));

    always_comb begin
        w_alu_sel = 3'd0;                       // PASS (LDA and non-ALU opcodes)
        case (w_op)
            C_OP_ADD: w_alu_sel = 3'd1;
            C_OP_AND: w_alu_sel = 3'd2;
            C_OP_XOR: w_alu_sel = 3'd3;
            C_OP_SUB: w_alu_sel = 3'd4;
            C_OP_OR:  w_alu_sel = 3'd5;
            default:  w_alu_sel = 3'd0;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_set_ill   = 1'b0;
        w_set_to    = 1'b0;
        w_retire    = 1'b0;
        w_wait_inc  = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_en     = 1'b0;
        w_halt      = 1'b0;
        w_jmp       = 1'b0;
        w_ir_load   = 1'b0;
        w_acc_load  = 1'b0;
        w_alu_op    = 3'd0;
        w_memIns_en = 1'b0;
        w_memDa_en  = 1'b0;
        w_memDa_we  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memIns_en = 1'b1;
                w_ir_load   = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_pc_en = 1'b1;
                if ((w_op == C_OP_HLT) || w_illegal) begin
                    w_next    = S_HALT;
                    w_set_ill = w_illegal;
                end else if (w_is_alu) begin
                    w_next = S_OP_FETCH;
                end else if (w_op == C_OP_STO) begin
                    w_next = S_STORE;
                end else begin
                    w_next = S_EXEC;            // SKZ / SKN / JMP / JZ
                end
            end
            S_OP_FETCH: begin
                w_memDa_en = 1'b1;
                w_alu_op   = w_alu_sel;
                // mem_ready takes priority over the timeout on the limit cycle.
                if (bus.mem_ready) begin
                    w_next = S_EXEC;
                end else if (w_at_limit) begin
                    w_next   = S_HALT;
                    w_set_to = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    w_acc_load = 1'b1;
                    w_alu_op   = w_alu_sel;
                end
                if (((w_op == C_OP_SKZ) && bus.is_zero) || ((w_op == C_OP_SKN) && bus.is_neg)) begin
                    w_pc_en = 1'b1;
                end
                if ((w_op == C_OP_JMP) || ((w_op == C_OP_JZ) && bus.is_zero)) begin
                    w_pc_load = 1'b1;
                    w_jmp     = 1'b1;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_STORE: begin
                w_memDa_en = 1'b1;
                w_memDa_we = 1'b1;
                if (bus.mem_ready) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_at_limit) begin
                    w_next   = S_HALT;
                    w_set_to = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_HALT: begin
                w_halt = 1'b1;
                // Any sticky error makes the halt terminal until reset.
                if (bus.resume && !r_err_illegal && !r_err_timeout) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;            // the HLT itself retires here
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            // Cleared whenever not waiting, so every entry starts at zero.
            r_wait_cnt <= w_wait_inc ? (r_wait_cnt + WAIT_W'(1)) : '0;
            if (w_set_ill) r_err_illegal <= 1'b1;
            if (w_set_to)  r_err_timeout <= 1'b1;
            if (w_retire && (r_instr_count != {CNT_W{1'b1}})) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    // Control strobes are masked by reset so they drop the instant rst falls,
    // independent of the state register's own asynchronous clear.
    assign bus.pc_load          = rst & w_pc_load;
    assign bus.pc_en            = rst & w_pc_en;
    assign bus.halt             = rst & w_halt;
    assign bus.jmp              = rst & w_jmp;
    assign bus.ir_load          = rst & w_ir_load;
    assign bus.accumulator_load = rst & w_acc_load;
    assign bus.alu_op           = rst ? w_alu_op : 3'd0;
    assign bus.memIns_en        = rst & w_memIns_en;
    assign bus.memDa_en         = rst & w_memDa_en;
    assign bus.memDa_we         = rst & w_memDa_we;
    assign bus.state            = r_state;
    assign bus.err_illegal      = r_err_illegal;
    assign bus.err_timeout      = r_err_timeout;
    assign bus.instr_count      = r_instr_count;
endmodule
`default_nettype wire

// File: tb/tb_cpu_control_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_mc
// Description : Self-checking bench for cpu_control_mc. The stimulus process
//               drives each cycle's inputs and queues the hand-derived
//               expected outputs; a monitor pops and compares on the falling
//               edge. Counter width is reduced to 4 bits so saturation is
//               reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_mc;
    localparam int C_CNT_W = 4;

    // ctl vector: {pc_load, pc_en, halt, jmp, ir_load, acc_load,
    //              memIns_en, memDa_en, memDa_we}
    localparam logic [8:0] C_ZERO  = 9'h000;
    localparam logic [8:0] C_FETCH = 9'h014;
    localparam logic [8:0] C_PCEN  = 9'h080;
    localparam logic [8:0] C_OPF   = 9'h002;
    localparam logic [8:0] C_ACC   = 9'h008;
    localparam logic [8:0] C_JUMP  = 9'h120;
    localparam logic [8:0] C_STO   = 9'h003;
    localparam logic [8:0] C_HALT  = 9'h040;

    typedef struct {
        string              name;
        logic [3:0]         st;
        logic [8:0]         ctl;
        logic [2:0]         alu;
        logic               ill;
        logic               to;
        logic [C_CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_control_mc_if #(.OPCODE_W(4), .CNT_W(C_CNT_W)) bus ();

    cpu_control_mc #(
        .OPCODE_W    (4),
        .MEM_WAIT_MAX(15),
        .CNT_W       (C_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t               sb[$];
    int                 checks = 0;
    int                 errors = 0;
    logic               exp_ill = 1'b0;
    logic               exp_to  = 1'b0;
    logic [C_CNT_W-1:0] exp_cnt = '0;

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {bus.pc_load, bus.pc_en, bus.halt, bus.jmp, bus.ir_load,
                   bus.accumulator_load, bus.memIns_en, bus.memDa_en, bus.memDa_we};
            checks++;
            if ((bus.state !== e.st) || (act !== e.ctl) || (bus.alu_op !== e.alu) ||
                (bus.err_illegal !== e.ill) || (bus.err_timeout !== e.to) ||
                (bus.instr_count !== e.cnt)) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%03h alu=%0d ill=%0b to=%0b cnt=%0d, want st=%0d ctl=%03h alu=%0d ill=%0b to=%0b cnt=%0d",
                         e.name, bus.state, act, bus.alu_op, bus.err_illegal, bus.err_timeout,
                         bus.instr_count, e.st, e.ctl, e.alu, e.ill, e.to, e.cnt);
            end
        end
    end

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic c(input string n, input logic [3:0] st, input logic [8:0] ctl,
                     input logic [2:0] alu);
        exp_t e;
        e.name = n; e.st = st; e.ctl = ctl; e.alu = alu;
        e.ill = exp_ill; e.to = exp_to; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        if (exp_cnt != {C_CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic run_alu(input logic [3:0] op, input logic [2:0] alu, input string n);
        bus.opcode = op; bus.mem_ready = 1'b1;
        c({n, "_fetch"}, 4'd0, C_FETCH, 3'd0);
        c({n, "_decode"}, 4'd1, C_PCEN, 3'd0);
        c({n, "_opfetch"}, 4'd2, C_OPF, alu);
        c({n, "_exec"}, 4'd3, C_ACC, alu);
        retire();
    endtask

    task automatic run_br(input logic [3:0] op, input logic z, input logic ng,
                          input logic [8:0] ctl, input string n);
        bus.opcode = op; bus.is_zero = z; bus.is_neg = ng;
        c({n, "_fetch"}, 4'd0, C_FETCH, 3'd0);
        c({n, "_decode"}, 4'd1, C_PCEN, 3'd0);
        c({n, "_exec"}, 4'd3, ctl, 3'd0);
        retire();
        bus.is_zero = 1'b0; bus.is_neg = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.opcode = '0; bus.is_zero = 1'b0; bus.is_neg = 1'b0;
        bus.mem_ready = 1'b0; bus.resume = 1'b0;
        @(posedge clk);
        #1;
        c("reset", 4'd0, C_ZERO, 3'd0);
        rst = 1'b1;

        // ALU / load instructions, memory ready on first access
        run_alu(4'd2,  3'd1, "add");
        run_alu(4'd3,  3'd2, "and");
        run_alu(4'd4,  3'd3, "xor");
        run_alu(4'd5,  3'd0, "lda");
        run_alu(4'd9,  3'd4, "sub");
        run_alu(4'd10, 3'd5, "or");

        // STO with three wait cycles
        bus.opcode = 4'd6; bus.mem_ready = 1'b1;
        c("sto_fetch", 4'd0, C_FETCH, 3'd0);
        c("sto_decode", 4'd1, C_PCEN, 3'd0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) c("sto_wait", 4'd4, C_STO, 3'd0);
        bus.mem_ready = 1'b1;
        c("sto_done", 4'd4, C_STO, 3'd0);
        retire();

        // Skips and jumps
        run_br(4'd1,  1'b1, 1'b0, C_PCEN, "skz_taken");
        run_br(4'd1,  1'b0, 1'b0, C_ZERO, "skz_not");
        run_br(4'd8,  1'b0, 1'b1, C_PCEN, "skn_taken");
        run_br(4'd8,  1'b1, 1'b0, C_ZERO, "skn_not");
        run_br(4'd7,  1'b0, 1'b0, C_JUMP, "jmp");
        run_br(4'd11, 1'b1, 1'b0, C_JUMP, "jz_taken");
        run_br(4'd11, 1'b0, 1'b1, C_ZERO, "jz_not");

        // HLT, held until resume; the resume retires it (count reaches 15)
        bus.opcode = 4'd0;
        c("hlt_fetch", 4'd0, C_FETCH, 3'd0);
        c("hlt_decode", 4'd1, C_PCEN, 3'd0);
        c("hlt_hold0", 4'd8, C_HALT, 3'd0);
        c("hlt_hold1", 4'd8, C_HALT, 3'd0);
        bus.resume = 1'b1;
        c("hlt_resume", 4'd8, C_HALT, 3'd0);
        retire();
        bus.resume = 1'b0;

        // Counter saturation: two more retirements hold at 15
        run_br(4'd7, 1'b0, 1'b0, C_JUMP, "sat_jmp0");
        run_br(4'd7, 1'b0, 1'b0, C_JUMP, "sat_jmp1");

        // Reset asserted while waiting in OP_FETCH
        bus.opcode = 4'd2; bus.mem_ready = 1'b0;
        c("midrst_fetch", 4'd0, C_FETCH, 3'd0);
        c("midrst_decode", 4'd1, C_PCEN, 3'd0);
        c("midrst_opfetch", 4'd2, C_OPF, 3'd1);
        rst = 1'b0;
        exp_cnt = '0;
        c("midrst_low0", 4'd0, C_ZERO, 3'd0);
        c("midrst_low1", 4'd0, C_ZERO, 3'd0);
        rst = 1'b1;

        // Illegal opcode: terminal halt, resume ignored
        bus.opcode = 4'd13;
        c("ill_fetch", 4'd0, C_FETCH, 3'd0);
        c("ill_decode", 4'd1, C_PCEN, 3'd0);
        exp_ill = 1'b1;
        c("ill_halt", 4'd8, C_HALT, 3'd0);
        bus.resume = 1'b1;
        c("ill_resume0", 4'd8, C_HALT, 3'd0);
        c("ill_resume1", 4'd8, C_HALT, 3'd0);
        bus.resume = 1'b0;
        rst = 1'b0;
        exp_ill = 1'b0;
        c("ill_reset", 4'd0, C_ZERO, 3'd0);
        rst = 1'b1;

        // mem_ready arrives exactly on the limit cycle: no timeout
        bus.opcode = 4'd5; bus.mem_ready = 1'b1;
        c("lim_fetch", 4'd0, C_FETCH, 3'd0);
        c("lim_decode", 4'd1, C_PCEN, 3'd0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) c("lim_wait", 4'd2, C_OPF, 3'd0);
        bus.mem_ready = 1'b1;
        c("lim_ready", 4'd2, C_OPF, 3'd0);
        c("lim_exec", 4'd3, C_ACC, 3'd0);
        retire();

        // LDA with memory never ready: 16 OP_FETCH cycles then timeout halt
        bus.opcode = 4'd5;
        c("to_fetch", 4'd0, C_FETCH, 3'd0);
        c("to_decode", 4'd1, C_PCEN, 3'd0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) c("to_wait", 4'd2, C_OPF, 3'd0);
        exp_to = 1'b1;
        c("to_halt", 4'd8, C_HALT, 3'd0);
        bus.resume = 1'b1;
        c("to_resume0", 4'd8, C_HALT, 3'd0);
        c("to_resume1", 4'd8, C_HALT, 3'd0);
        bus.resume = 1'b0;

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
